// File: rtl/d_cache_nway_wb_pkg.sv
// dcache_pkg: shared definitions for the N-way write-back data cache.
//   state_t      - controller state encoding (IDLE, WB, RF, RESP, UC)
//   SIZE_*       - sram-like transfer size codes (byte / half / word)
//   write_mask() - byte enables for a store of a given size at addr[1:0]
//   merge_word() - byte-masked merge of store data into an existing word
package dcache_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WB   = 3'd1,
        S_RF   = 3'd2,
        S_RESP = 3'd3,
        S_UC   = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Store data arrives already placed in its byte lane(s); only the lanes
    // selected here are taken from it.
    function automatic logic [3:0] write_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_BYTE: return 4'b0001 << lo;
            SIZE_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = mask[b] ? wdata[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/d_cache_nway_wb_if.sv
// d_cache_nway_wb_if: sram-like bus used on both sides of the data cache.
//   req/wr/size/addr/wdata : request, driven by the master
//   rdata/addr_ok/data_ok  : response, driven by the slave
// Handshake: the master holds req and the request fields stable until the
// slave raises addr_ok (request accepted on that clock edge); the transfer
// completes on the cycle data_ok is high, when rdata is valid for reads.
// addr_ok and data_ok may be high in the same cycle.
interface d_cache_nway_wb_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
    modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/d_cache_nway_wb_lru.sv
// dcache_lru: per-set true-LRU age storage for the data cache.
//   clk, rst : clock, synchronous active-high reset (age[w] = w in every set)
//   index    : set being looked up / updated
//   valid    : valid bits of that set's ways
//   upd_en   : mark upd_way as most recently used in set index
//   victim   : lowest-index invalid way, else the oldest way (age WAY_NUM-1)
module dcache_lru #(
    parameter int WAY_NUM     = 4,
    parameter int INDEX_WIDTH = 7,
    localparam int WAY_W      = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] index,
    input  logic [WAY_NUM-1:0]     valid,
    input  logic                   upd_en,
    input  logic [WAY_W-1:0]       upd_way,
    output logic [WAY_W-1:0]       victim
);
    localparam int SETS = 1 << INDEX_WIDTH;

    logic [WAY_W-1:0] age [SETS][WAY_NUM];

    // Ages within a set are always a permutation of 0..WAY_NUM-1: the touched
    // way drops to 0 and only ways younger than it age by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAY_NUM; w++) begin
                    age[s][w] <= WAY_W'(w);
                end
            end
        end else if (upd_en) begin
            for (int w = 0; w < WAY_NUM; w++) begin
                if (WAY_W'(w) == upd_way) begin
                    age[index][w] <= '0;
                end else if (age[index][w] < age[index][upd_way]) begin
                    age[index][w] <= age[index][w] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic found;
        found  = 1'b0;
        victim = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            if (!valid[w] && !found) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAY_NUM; w++) begin
                if (age[index][w] == WAY_W'(WAY_NUM - 1)) victim = WAY_W'(w);
            end
        end
    end
endmodule

// File: rtl/d_cache_nway_wb.sv
// d_cache_nway_wb: N-way set-associative, write-back, write-allocate data
// cache with multi-word lines, true LRU and uncached bypass.
//   clk, rst  : clock, synchronous active-high reset
//   except    : current access is from an excepting instruction (acked, no effect)
//   no_cache  : access bypasses the cache (single memory transfer)
//   cpu       : sram-like slave port towards the core data port
//   mem       : sram-like master port towards the AXI adaptor (word beats)
//   dbg_state : current controller state
//   perf_*    : hit / miss / writeback counters, present only when
//               DCACHE_PERF_CNT_EN is defined
module d_cache_nway_wb
    import dcache_pkg::*;
#(
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 4,
    parameter int WAY_NUM      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              except,
    input  logic              no_cache,
    d_cache_nway_wb_if.slave  cpu,
    d_cache_nway_wb_if.master mem,
`ifdef DCACHE_PERF_CNT_EN
    output logic [31:0]       perf_hit_cnt,
    output logic [31:0]       perf_miss_cnt,
    output logic [31:0]       perf_wb_cnt,
`endif
    output state_t            dbg_state
);
    localparam int TAG_WIDTH  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int SETS       = 1 << INDEX_WIDTH;
    localparam int WORD_W     = OFFSET_WIDTH - 2;
    localparam int LINE_WORDS = 1 << WORD_W;
    localparam int WAY_W      = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

    state_t state, next_state;

    logic [31:0]          data_mem  [WAY_NUM][SETS][LINE_WORDS];
    logic [TAG_WIDTH-1:0] tag_mem   [WAY_NUM][SETS];
    logic [WAY_NUM-1:0]   valid_mem [SETS];
    logic [WAY_NUM-1:0]   dirty_mem [SETS];

    logic [TAG_WIDTH-1:0]   cpu_tag;
    logic [INDEX_WIDTH-1:0] cpu_index;
    logic [WORD_W-1:0]      cpu_word;
    assign cpu_tag   = cpu.addr[31 -: TAG_WIDTH];
    assign cpu_index = cpu.addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign cpu_word  = cpu.addr[2 +: WORD_W];

    logic [31:0]      cap_addr, cap_wdata;
    logic             cap_wr;
    logic [1:0]       cap_size;
    logic [WAY_W-1:0] cap_way;
    logic [TAG_WIDTH-1:0]   cap_tag;
    logic [INDEX_WIDTH-1:0] cap_index;
    logic [WORD_W-1:0]      cap_word;
    assign cap_tag   = cap_addr[31 -: TAG_WIDTH];
    assign cap_index = cap_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign cap_word  = cap_addr[2 +: WORD_W];

    logic [WORD_W-1:0] beat;
    logic              wait_data;   // beat accepted, waiting for its data_ok

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            if (valid_mem[cpu_index][w] && tag_mem[w][cpu_index] == cpu_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    logic             lru_upd_en;
    logic [WAY_W-1:0] lru_upd_way, victim_way;
    dcache_lru #(.WAY_NUM(WAY_NUM), .INDEX_WIDTH(INDEX_WIDTH)) u_lru (
        .clk     (clk),
        .rst     (rst),
        .index   ((state == S_IDLE) ? cpu_index : cap_index),
        .valid   (valid_mem[cpu_index]),
        .upd_en  (lru_upd_en),
        .upd_way (lru_upd_way),
        .victim  (victim_way)
    );

    logic [31:0] hit_word, resp_word;
    logic        acc_ok, hit_acc, miss_acc, hit_wr, resp_wr, victim_dirty;
    logic        mem_phase, beat_done, last_beat, rf_beat, rf_done;
    assign hit_word     = data_mem[hit_way][cpu_index][cpu_word];
    assign resp_word    = data_mem[cap_way][cap_index][cap_word];
    assign acc_ok       = (state == S_IDLE) && cpu.req && !except && !no_cache;
    assign hit_acc      = acc_ok && hit;
    assign miss_acc     = acc_ok && !hit;
    assign hit_wr       = hit_acc && cpu.wr;
    assign resp_wr      = (state == S_RESP) && cap_wr;
    assign victim_dirty = valid_mem[cpu_index][victim_way] && dirty_mem[cpu_index][victim_way];
    assign mem_phase    = (state == S_WB) || (state == S_RF) || (state == S_UC);
    // A beat completes on data_ok, including data_ok in its own addr_ok cycle.
    assign beat_done    = mem_phase && ((!wait_data && mem.addr_ok && mem.data_ok) ||
                                        (wait_data && mem.data_ok));
    assign last_beat    = (beat == WORD_W'(LINE_WORDS - 1));
    assign rf_beat      = (state == S_RF) && beat_done;
    assign rf_done      = rf_beat && last_beat;
    assign dbg_state    = state;

    always_comb begin
        next_state    = state;
        cpu.addr_ok   = 1'b0;
        cpu.data_ok   = 1'b0;
        cpu.rdata     = '0;
        mem.req       = 1'b0;
        mem.wr        = 1'b0;
        mem.size      = 2'd0;
        mem.addr      = '0;
        mem.wdata     = '0;
        lru_upd_en    = 1'b0;
        lru_upd_way   = hit_way;
        case (state)
            S_IDLE: if (cpu.req) begin
                if (except) begin
                    cpu.addr_ok = 1'b1;
                    cpu.data_ok = 1'b1;
                end else if (no_cache) begin
                    next_state = S_UC;
                end else if (hit) begin
                    cpu.addr_ok = 1'b1;
                    cpu.data_ok = 1'b1;
                    cpu.rdata   = hit_word;
                    lru_upd_en  = 1'b1;
                end else begin
                    next_state = victim_dirty ? S_WB : S_RF;
                end
            end
            S_WB: begin
                mem.req   = !wait_data;
                mem.wr    = 1'b1;
                mem.size  = SIZE_WORD;
                mem.addr  = {tag_mem[cap_way][cap_index], cap_index, beat, 2'b00};
                mem.wdata = data_mem[cap_way][cap_index][beat];
                if (beat_done && last_beat) next_state = S_RF;
            end
            S_RF: begin
                mem.req  = !wait_data;
                mem.size = SIZE_WORD;
                mem.addr = {cap_tag, cap_index, beat, 2'b00};
                if (rf_done) next_state = S_RESP;
            end
            S_RESP: begin
                cpu.addr_ok = 1'b1;
                cpu.data_ok = 1'b1;
                cpu.rdata   = resp_word;
                lru_upd_en  = 1'b1;
                lru_upd_way = cap_way;
                next_state  = S_IDLE;
            end
            S_UC: begin
                mem.req   = !wait_data;
                mem.wr    = cap_wr;
                mem.size  = cap_size;
                mem.addr  = cap_addr;
                mem.wdata = cap_wdata;
                if (beat_done) begin
                    cpu.addr_ok = 1'b1;
                    cpu.data_ok = 1'b1;
                    cpu.rdata   = mem.rdata;
                    next_state  = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            beat      <= '0;
            wait_data <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wr    <= 1'b0;
            cap_size  <= 2'd0;
            cap_way   <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && next_state != S_IDLE) begin
                cap_addr  <= cpu.addr;
                cap_wdata <= cpu.wdata;
                cap_wr    <= cpu.wr;
                cap_size  <= cpu.size;
                cap_way   <= victim_way;
                beat      <= '0;
                wait_data <= 1'b0;
            end else if (beat_done) begin
                beat      <= beat + 1'b1;   // wraps to 0 between WB and RF
                wait_data <= 1'b0;
            end else if (mem.req && mem.addr_ok) begin
                wait_data <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
            end
        end else begin
            if (hit_wr)  dirty_mem[cpu_index][hit_way] <= 1'b1;
            if (resp_wr) dirty_mem[cap_index][cap_way] <= 1'b1;
            if (rf_done) begin
                valid_mem[cap_index][cap_way] <= 1'b1;
                dirty_mem[cap_index][cap_way] <= 1'b0;
            end
        end
    end

    // Line data and tags carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (hit_wr)
                data_mem[hit_way][cpu_index][cpu_word] <=
                    merge_word(hit_word, cpu.wdata, write_mask(cpu.size, cpu.addr[1:0]));
            if (resp_wr)
                data_mem[cap_way][cap_index][cap_word] <=
                    merge_word(resp_word, cap_wdata, write_mask(cap_size, cap_addr[1:0]));
            if (rf_beat) data_mem[cap_way][cap_index][beat] <= mem.rdata;
            if (rf_done) tag_mem[cap_way][cap_index] <= cap_tag;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hit_cnt  <= '0;
            perf_miss_cnt <= '0;
            perf_wb_cnt   <= '0;
        end else begin
            if (hit_acc)  perf_hit_cnt  <= perf_hit_cnt + 1'b1;
            if (miss_acc) perf_miss_cnt <= perf_miss_cnt + 1'b1;
            if (state == S_IDLE && next_state == S_WB) perf_wb_cnt <= perf_wb_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_d_cache_nway_wb.sv
// Testbench for d_cache_nway_wb (default parameters: 128 sets, 4-word lines,
// 4 ways). A memory responder answers on the mem port; expected core
// responses and expected memory transfers are queued by the stimulus and
// checked by two independent monitors.
module tb_d_cache_nway_wb;
    import dcache_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    logic   except;
    logic   no_cache;
    logic   fast = 1'b0;          // memory gives addr_ok and data_ok in one cycle
    state_t dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] exp_q[$];        // {check_rdata, rdata}
    logic [66:0] exp_mem_q[$];    // {wr, size, addr, wdata}
    logic [32:0] cpu_e;
    logic [66:0] mem_e;

    logic        dok_r = 1'b0;
    logic [31:0] rd_r  = '0;

    d_cache_nway_wb_if cpu_bus();
    d_cache_nway_wb_if mem_bus();

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] perf_hit_cnt, perf_miss_cnt, perf_wb_cnt;
`endif

    d_cache_nway_wb dut (
        .clk       (clk),
        .rst       (rst),
        .except    (except),
        .no_cache  (no_cache),
        .cpu       (cpu_bus.slave),
        .mem       (mem_bus.master),
`ifdef DCACHE_PERF_CNT_EN
        .perf_hit_cnt  (perf_hit_cnt),
        .perf_miss_cnt (perf_miss_cnt),
        .perf_wb_cnt   (perf_wb_cnt),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- memory model ----------------
    // Line 0x1000 reads back 0xA0..0xA3; everything else reads addr ^ 0xC0DE0000.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h0000100) return 32'hA0 + {28'd0, a[3:2]};
        return a ^ 32'hC0DE_0000;
    endfunction

    assign mem_bus.addr_ok = mem_bus.req;
    assign mem_bus.data_ok = fast ? mem_bus.req : dok_r;
    assign mem_bus.rdata   = fast ? mem_word(mem_bus.addr) : rd_r;

    always @(posedge clk) begin
        dok_r <= 1'b0;
        if (mem_bus.req && !fast) begin
            dok_r <= 1'b1;
            rd_r  <= mem_word(mem_bus.addr);
        end
    end

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (mem_bus.req && mem_bus.addr_ok) begin
            n_tests++;
            if (exp_mem_q.size() == 0) begin
                n_fail++;
                $display("FAIL mem_unexpected: got wr=%0b size=%0d addr=%h wdata=%h, none expected",
                         mem_bus.wr, mem_bus.size, mem_bus.addr, mem_bus.wdata);
            end else begin
                mem_e = exp_mem_q.pop_front();
                if (mem_bus.wr !== mem_e[66] || mem_bus.size !== mem_e[65:64] ||
                    mem_bus.addr !== mem_e[63:32] || (mem_e[66] && mem_bus.wdata !== mem_e[31:0])) begin
                    n_fail++;
                    $display("FAIL mem_txn: got wr=%0b size=%0d addr=%h wdata=%h expected wr=%0b size=%0d addr=%h wdata=%h",
                             mem_bus.wr, mem_bus.size, mem_bus.addr, mem_bus.wdata,
                             mem_e[66], mem_e[65:64], mem_e[63:32], mem_e[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cpu_bus.data_ok) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL cpu_unexpected: got data_ok with rdata=%h, none expected", cpu_bus.rdata);
            end else begin
                cpu_e = exp_q.pop_front();
                if (cpu_e[32]) begin
                    n_tests++;
                    if (cpu_bus.rdata !== cpu_e[31:0]) begin
                        n_fail++;
                        $display("FAIL cpu_rdata: got %h expected %h", cpu_bus.rdata, cpu_e[31:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_mem_q.push_back({1'b0, SIZE_WORD, 32'(base + 4 * i), 32'h0});
    endtask

    task automatic exp_wr(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        exp_mem_q.push_back({1'b1, sz, a, d});
    endtask

    // lat = cycles between raising req and the cycle addr_ok is seen (0 = same cycle)
    task automatic cpu_access(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] wd, input logic exc, input logic nc,
                              input logic chk, input logic [31:0] exp_rd, output int lat);
        exp_q.push_back({chk, exp_rd});
        @(posedge clk); #1;
        cpu_bus.req   = 1'b1;
        cpu_bus.wr    = wr;
        cpu_bus.size  = sz;
        cpu_bus.addr  = a;
        cpu_bus.wdata = wd;
        except        = exc;
        no_cache      = nc;
        lat = 0;
        forever begin
            @(negedge clk);
            if (cpu_bus.addr_ok) break;
            lat++;
            if (lat > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL cpu_timeout: addr=%h got no addr_ok expected within 200 cycles", a);
                break;
            end
        end
        @(posedge clk); #1;
        cpu_bus.req = 1'b0;
        cpu_bus.wr  = 1'b0;
        except      = 1'b0;
        no_cache    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, output int lat);
        cpu_access(1'b0, SIZE_WORD, a, 32'h0, 1'b0, 1'b0, 1'b1, e, lat);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, output int lat);
        cpu_access(1'b1, sz, a, d, 1'b0, 1'b0, 1'b0, 32'h0, lat);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int cnt;
        rst = 1'b1; except = 1'b0; no_cache = 1'b0;
        cpu_bus.req = 1'b0; cpu_bus.wr = 1'b0; cpu_bus.size = 2'd0;
        cpu_bus.addr = '0; cpu_bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state",   32'(dbg_state), 32'(S_IDLE));
        check("reset_addr_ok", 32'(cpu_bus.addr_ok), 32'd0);
        check("reset_data_ok", 32'(cpu_bus.data_ok), 32'd0);
        check("reset_rdata",   cpu_bus.rdata, 32'd0);
        check("reset_mem_req", 32'(mem_bus.req), 32'd0);

        // Cold read miss, then hit on the same word.
        exp_line(32'h1000);
        rd(32'h1004, 32'hA1, lat);              check("cold_miss_lat", 32'(lat != 0), 32'd1);
        rd(32'h1004, 32'hA1, lat);              check("hit_lat", 32'(lat), 32'd0);

        // Store hits: sw, sb, sh byte-masked merges.
        st(SIZE_WORD, 32'h1000, 32'h1122_3344, lat); check("sw_hit_lat", 32'(lat), 32'd0);
        st(SIZE_BYTE, 32'h1002, 32'h00FF_0000, lat);
        rd(32'h1000, 32'h11FF_3344, lat);
        st(SIZE_HALF, 32'h100A, 32'hBEEF_0000, lat);
        rd(32'h1008, 32'hBEEF_00A2, lat);

        // LRU in set 0: tags 0x1000(way0) 0x2000 0x3000 0x4000, touch 0x1000, then 0x5000
        exp_line(32'h2000); rd(32'h2000, 32'hC0DE_2000, lat);
        exp_line(32'h3000); rd(32'h3004, 32'hC0DE_3004, lat);
        exp_line(32'h4000); rd(32'h4008, 32'hC0DE_4008, lat);
        rd(32'h1000, 32'h11FF_3344, lat);        check("touch_tag0_lat", 32'(lat), 32'd0);
        exp_line(32'h5000); rd(32'h500C, 32'hC0DE_500C, lat);
        rd(32'h1004, 32'hA1, lat);               check("tag0_kept_lat", 32'(lat), 32'd0);
        exp_line(32'h2000); rd(32'h2004, 32'hC0DE_2004, lat);
        check("tag1_evicted_lat", 32'(lat != 0), 32'd1);
        rd(32'h4000, 32'hC0DE_4000, lat);        check("tag3_hit_lat", 32'(lat), 32'd0);
        rd(32'h5000, 32'hC0DE_5000, lat);        check("tag4_hit_lat", 32'(lat), 32'd0);

        // Dirty 0x1000 line is now the oldest: writeback then refill.
        exp_wr(SIZE_WORD, 32'h1000, 32'h11FF_3344);
        exp_wr(SIZE_WORD, 32'h1004, 32'h0000_00A1);
        exp_wr(SIZE_WORD, 32'h1008, 32'hBEEF_00A2);
        exp_wr(SIZE_WORD, 32'h100C, 32'h0000_00A3);
        exp_line(32'h6000); rd(32'h6008, 32'hC0DE_6008, lat);
        exp_line(32'h1000); rd(32'h1000, 32'hA0, lat);
        check("reread_after_wb_lat", 32'(lat != 0), 32'd1);

        // Uncached accesses: no array change.
        exp_wr(SIZE_WORD, 32'hBFC0_0000, 32'h5);
        cpu_access(1'b1, SIZE_WORD, 32'hBFC0_0000, 32'h5, 1'b0, 1'b1, 1'b0, 32'h0, lat);
        exp_wr(SIZE_BYTE, 32'h1001, 32'h0000_AB00);
        cpu_access(1'b1, SIZE_BYTE, 32'h1001, 32'h0000_AB00, 1'b0, 1'b1, 1'b0, 32'h0, lat);
        exp_mem_q.push_back({1'b0, SIZE_WORD, 32'hBFC0_0004, 32'h0});
        cpu_access(1'b0, SIZE_WORD, 32'hBFC0_0004, 32'h0, 1'b0, 1'b1, 1'b1, 32'h7F1E_0004, lat);
        rd(32'h1000, 32'hA0, lat);               check("uc_line_untouched_lat", 32'(lat), 32'd0);
        exp_line(32'h0010); rd(32'h0018, 32'hC0DE_0018, lat);
        check("other_set_miss_lat", 32'(lat != 0), 32'd1);

        // Excepting accesses: immediate ack, rdata 0, no side effects.
        cpu_access(1'b0, SIZE_WORD, 32'h7000, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, lat);
        check("except_miss_lat", 32'(lat), 32'd0);
        cpu_access(1'b1, SIZE_WORD, 32'h1000, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0, lat);
        cpu_access(1'b0, SIZE_WORD, 32'h1000, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, lat);
        rd(32'h1000, 32'hA0, lat);               check("except_no_write_lat", 32'(lat), 32'd0);

        // addr_ok and data_ok in the same cycle.
        fast = 1'b1;
        exp_line(32'h0020); rd(32'h0024, 32'hC0DE_0024, lat);
        check("fast_miss_lat", 32'(lat != 0), 32'd1);
        exp_mem_q.push_back({1'b0, SIZE_WORD, 32'hBFC0_0008, 32'h0});
        cpu_access(1'b0, SIZE_WORD, 32'hBFC0_0008, 32'h0, 1'b0, 1'b1, 1'b1, 32'h7F1E_0008, lat);
        fast = 1'b0;

        // Reset during beat 2 of a refill.
        exp_mem_q.push_back({1'b0, SIZE_WORD, 32'h0000_0030, 32'h0});
        exp_mem_q.push_back({1'b0, SIZE_WORD, 32'h0000_0034, 32'h0});
        exp_mem_q.push_back({1'b0, SIZE_WORD, 32'h0000_0038, 32'h0});
        @(posedge clk); #1;
        cpu_bus.req = 1'b1; cpu_bus.wr = 1'b0; cpu_bus.size = SIZE_WORD; cpu_bus.addr = 32'h34;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_bus.req && mem_bus.addr == 32'h38) break;
            cnt++;
            if (cnt > 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL rf_beat2_timeout: got no beat 2 request expected within 100 cycles");
                break;
            end
        end
        rst = 1'b1;
        cpu_bus.req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_state",   32'(dbg_state), 32'(S_IDLE));
        check("mid_rst_mem_req", 32'(mem_bus.req), 32'd0);
        exp_line(32'h1000); rd(32'h1000, 32'hA0, lat);
        check("rst_invalidates_lat", 32'(lat != 0), 32'd1);

        repeat (3) @(negedge clk);
        check("cpu_queue_empty", 32'(exp_q.size()), 32'd0);
        check("mem_queue_empty", 32'(exp_mem_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
